// File: rtl/mem_pkg.sv
// Shared types and helpers for the parametrised memory controller.
package mem_pkg;

   // Controller operating state: self-clear sweep or normal request service.
   typedef enum logic {ST_CLEAR, ST_RUN} mem_state_t;

   // Address width for a given depth; keeps at least one bit for DEPTH = 1.
   function automatic int unsigned addr_w_f(input int unsigned depth);
      return (depth <= 32'd1) ? 32'd1 : int'($clog2(depth));
   endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read response delay line: carries {valid, err, data} through LAT stages.
// Data and err are forced to zero on stages that hold no response.
module mem_rd_pipe #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned LAT    = 1
) (
   input  logic              clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   input  logic              i_err,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   output logic              o_err,
   output logic [DATA_W-1:0] o_data
);

   logic              r_valid [LAT];
   logic              r_err   [LAT];
   logic [DATA_W-1:0] r_data  [LAT];

   // First stage captures the response with data gated by valid.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid[0] <= 1'b0;
         r_err[0]   <= 1'b0;
         r_data[0]  <= '0;
      end else begin
         r_valid[0] <= i_valid;
         r_err[0]   <= i_valid & i_err;
         r_data[0]  <= i_valid ? i_data : '0;
      end
   end

   // Remaining stages shift the already-gated response along.
   for (genvar k = 1; k < int'(LAT); k++) begin : g_stage
      always_ff @(posedge clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_valid[k] <= 1'b0;
            r_err[k]   <= 1'b0;
            r_data[k]  <= '0;
         end else begin
            r_valid[k] <= r_valid[k-1];
            r_err[k]   <= r_err[k-1];
            r_data[k]  <= r_data[k-1];
         end
      end
   end

   assign o_valid = r_valid[LAT-1];
   assign o_err   = r_err[LAT-1];
   assign o_data  = r_data[LAT-1];

endmodule

// File: rtl/param_mem_ctrl.sv
// Single-port synchronous memory with valid/ready requests, byte-enable
// writes, configurable read latency, range checking and self-clear.
module param_mem_ctrl
   import mem_pkg::*;
#(
   parameter  int unsigned DATA_W   = 32,
   parameter  int unsigned DEPTH    = 16,
   parameter  int unsigned READ_LAT = 1,
   localparam int unsigned ADDR_W   = addr_w_f(DEPTH),
   localparam int unsigned BE_W     = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [BE_W-1:0]   req_be,
   input  logic              clr_start,
   output logic              rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              rerr,
   output logic              init_done
);

   // Reject unsupported configurations at elaboration.
   if ((READ_LAT != 32'd1) && (READ_LAT != 32'd2)) begin : g_bad_lat
      $error("param_mem_ctrl: READ_LAT must be 1 or 2");
   end
   if ((DATA_W % 32'd8) != 32'd0) begin : g_bad_width
      $error("param_mem_ctrl: DATA_W must be a multiple of 8");
   end
   if (DEPTH < 32'd2) begin : g_bad_depth
      $error("param_mem_ctrl: DEPTH must be at least 2");
   end

   mem_state_t        r_state;
   logic [ADDR_W-1:0] r_ptr;
   logic              r_req_ready;
   logic              r_init_done;
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_acc;
   logic              w_in_range;
   logic              w_wr_acc;
   logic              w_rd_acc;
   logic [DATA_W-1:0] w_rd_data;

   assign w_acc      = req_valid & r_req_ready;
   assign w_in_range = (32'(req_addr) < DEPTH);
   assign w_wr_acc   = w_acc & req_wr & w_in_range;
   assign w_rd_acc   = w_acc & ~req_wr;
   assign w_rd_data  = w_in_range ? r_mem[req_addr] : '0;

   // Control FSM: clear sweep after reset or clr_start, then serve requests.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_CLEAR;
         r_ptr       <= '0;
         r_req_ready <= 1'b0;
         r_init_done <= 1'b0;
      end else begin
         case (r_state)
            ST_CLEAR: begin
               if (r_ptr == ADDR_W'(DEPTH - 32'd1)) begin
                  r_state     <= ST_RUN;
                  r_ptr       <= '0;
                  r_req_ready <= 1'b1;
                  r_init_done <= 1'b1;
               end else begin
                  r_ptr <= r_ptr + ADDR_W'(1);
               end
            end
            ST_RUN: begin
               if (clr_start) begin
                  r_state     <= ST_CLEAR;
                  r_ptr       <= '0;
                  r_req_ready <= 1'b0;
                  r_init_done <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_CLEAR;
               r_ptr       <= '0;
               r_req_ready <= 1'b0;
               r_init_done <= 1'b0;
            end
         endcase
      end
   end

   // Storage: zero one word per cycle while clearing, else byte-merge writes.
   always_ff @(posedge clk) begin
      if (r_state == ST_CLEAR) begin
         r_mem[r_ptr] <= '0;
      end else if (w_wr_acc) begin
         for (int b = 0; b < int'(BE_W); b++) begin
            if (req_be[b]) begin
               r_mem[req_addr][b*8 +: 8] <= req_wdata[b*8 +: 8];
            end
         end
      end
   end

   // Read responses travel through a fixed-latency pipe, even during clear.
   mem_rd_pipe #(
      .DATA_W (DATA_W),
      .LAT    (READ_LAT)
   ) u_rd_pipe (
      .clk     (clk),
      .i_rst_n (rst),
      .i_valid (w_rd_acc),
      .i_err   (~w_in_range),
      .i_data  (w_rd_data),
      .o_valid (rvalid),
      .o_err   (rerr),
      .o_data  (rdata)
   );

   assign req_ready = r_req_ready;
   assign init_done = r_init_done;

endmodule
